// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave view belongs to the loader; the master view is the stream source and memory sink.
interface imem_loader_if #(
   parameter int AW = 32
);
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          start;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_reset;
   logic          done;
   logic          error;

   modport slave (
      input  rx_valid, rx_data, start,
      output rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
   );

   modport master (
      output rx_valid, rx_data, start,
      input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// Assembles a byte-serial program image into little-endian words, writes them to
// instruction memory and releases the core from reset once the XOR checksum matches.
//
// state  | meaning
// LEN_LO | waiting for low byte of the word count
// LEN_HI | waiting for high byte of the word count
// DATA   | collecting data bytes, one memory write per 4 bytes
// CSUM   | waiting for the checksum byte
// DONE   | image loaded and verified, core released
// ERROR  | oversize image or bad checksum, core held in reset
module imem_loader #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    len_lo_q, len_lo_d;
   logic [15:0]   n_q, n_d;
   logic [15:0]   word_idx_q, word_idx_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic [7:0]    xor_q, xor_d;
   logic [23:0]   word_q, word_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;

   logic          rx_ready;
   logic          accept;
   logic [15:0]   n_rx;

   assign rx_ready = reset_ni && (state_q == LEN_LO || state_q == LEN_HI ||
                                  state_q == DATA   || state_q == CSUM);
   assign accept   = bus.rx_valid && rx_ready;
   assign n_rx     = {bus.rx_data, len_lo_q};

   always_comb begin
      state_d     = state_q;
      len_lo_d    = len_lo_q;
      n_d         = n_q;
      word_idx_d  = word_idx_q;
      byte_idx_d  = byte_idx_q;
      xor_d       = xor_q;
      word_d      = word_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         LEN_LO: begin
            if (accept) begin
               len_lo_d = bus.rx_data;
               state_d  = LEN_HI;
            end
         end
         LEN_HI: begin
            if (accept) begin
               n_d        = n_rx;
               word_idx_d = '0;
               byte_idx_d = '0;
               xor_d      = '0;
               if (int'(n_rx) > DEPTH)  state_d = ERROR;
               else if (n_rx == 16'd0)  state_d = CSUM;
               else                     state_d = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               xor_d      = xor_q ^ bus.rx_data;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: word_d[7:0]   = bus.rx_data;
                  2'd1: word_d[15:8]  = bus.rx_data;
                  2'd2: word_d[23:16] = bus.rx_data;
                  default: begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = {bus.rx_data, word_q};
                     mem_addr_d  = AW'({word_idx_q, 2'b00});
                     word_idx_d  = word_idx_q + 16'd1;
                     if (word_idx_q == n_q - 16'd1) state_d = CSUM;
                  end
               endcase
            end
         end
         CSUM: begin
            if (accept) state_d = (bus.rx_data == xor_q) ? DONE : ERROR;
         end
         DONE, ERROR: begin
            if (bus.start) state_d = LEN_LO;
         end
         default: state_d = LEN_LO;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= LEN_LO;
         len_lo_q    <= '0;
         n_q         <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         xor_q       <= '0;
         word_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         len_lo_q    <= len_lo_d;
         n_q         <= n_d;
         word_idx_q  <= word_idx_d;
         byte_idx_q  <= byte_idx_d;
         xor_q       <= xor_d;
         word_q      <= word_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.rx_ready  = rx_ready;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_reset = (state_q != DONE);
   assign bus.done      = (state_q == DONE);
   assign bus.error     = (state_q == ERROR);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the single-cycle MIPS core fetches from.
- Receives a byte-serial program image over a valid/ready stream and assembles it into little-endian 32-bit words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses starting at 0.
- Holds the core in reset until the whole image has arrived and its checksum matches.

Parameters:
- DEPTH, 256: capacity of the instruction memory in 32-bit words; longer images are rejected.
- AW, 32: width of mem_addr; byte address, same width as the core's PC.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-low reset.
- rx_valid  in  1  rx_data holds a valid byte.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- start  in  1  single-cycle pulse; restarts loading from DONE or ERROR.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  AW  byte address of the word being written (word-aligned).
- mem_wdata  out  32  word to write.
- cpu_reset  out  1  active-high reset for the core; 1 until load succeeds.
- done  out  1  load completed with good checksum (sticky).
- error  out  1  load failed (sticky).

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to LEN_LO; all partial data is discarded.
  - Outputs after that edge: mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
  - rx_ready is forced 0 while reset is low.
  - Reset mid-operation aborts immediately; no write strobe issues for a partial word.
- Byte transfer occurs on any posedge where rx_valid && rx_ready.
- rx_ready = 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in DONE and ERROR.
- Stream format: len_lo, len_hi, then 4*N data bytes, then 1 checksum byte.
  - N = {len_hi, len_lo} is the word count.
  - Data words are little-endian: first byte goes to bits 7:0.
  - Checksum = XOR of all data bytes only; the length bytes are excluded.
- State machine:
  - LEN_LO: accept a byte -> store len_lo -> LEN_HI.
  - LEN_HI: accept a byte -> form N, then:
    - N > DEPTH: ERROR on the same edge.
    - N == 0: CSUM.
    - otherwise: DATA; clear word index, byte index and running XOR.
  - DATA: each accepted byte goes into lane byte_idx (0..3) and is XORed into the running sum.
    - On acceptance of lane 3, the next cycle shows mem_we=1, mem_wdata = assembled word, mem_addr = word_idx*4.
    - Then word_idx increments.
    - After word N-1 is accepted, go to CSUM.
    - mem_we is never high for two consecutive cycles on its own; back-to-back words give one strobe every 4 or more cycles.
  - CSUM: accept a byte.
    - Equal to running XOR: DONE.
    - Otherwise: ERROR.
    - Words already written stay in memory.
  - DONE: done=1, cpu_reset=0 (the core leaves reset on the cycle after entry).
    - start=1: back to LEN_LO, cpu_reset=1 and done=0 on the next cycle.
  - ERROR: error=1, cpu_reset=1.
    - start=1: back to LEN_LO, error=0.
  - start is ignored in every other state.
- Stalls:
  - rx_valid may drop between any bytes; state and partial data hold.
  - There is no timeout.
- mem_addr / mem_wdata hold their last values while mem_we=0.
- rx_data beyond the stream (after CSUM) is not accepted, because rx_ready=0.

Test Plan:
1. Valid two-word image.
   - Stimulus: 02 00, then data 05 00 08 20 20 40 09 01, then checksum 45, back-to-back.
   - Required: mem_we pulses with (addr 0x0, data 0x20080005) and (addr 0x4, data 0x01094020).
   - After the checksum: done=1, cpu_reset=0, rx_ready=0.
2. Same stream with checksum 44.
   - Required: both writes still occur; error=1, done=0, cpu_reset stays 1.
3. Empty image: 00 00 00.
   - Required: no mem_we; done=1, cpu_reset=0.
4. Oversize image: 01 01 (N=257 > DEPTH 256).
   - Required: error=1 on the cycle after len_hi; rx_ready=0; no mem_we ever.
5. Scenario 1 with rx_valid low for 3 cycles between every byte, plus 0 and 5 cycle gaps.
   - Required: identical writes and final flags.
6. Reset mid-word, then restart.
   - Stimulus: reset low for 1 cycle after 02 00 05 00; then send the full scenario-1 stream.
   - Required: no write of a partial word; writes land at 0x0 and 0x4; done=1.
   - Then pulse start: cpu_reset=1 and done=0 the next cycle, and a new stream is accepted.
